// File: rtl/add_full_bist.sv
// ----------------------------------------------------------------------------
// add_full_bist
//   Logic-BIST controller for the ADD_FULL full-adder slice. Applies the
//   exhaustive pattern set 0..NPAT-1 on {x,y,cin}, compacts {s,cout} into a
//   rotate-and-XOR signature and flags pass/fail against GOLDEN.
//
//   Optional feature macro: BIST_RESP_REG_EN
//     Registers resp_i before the compactor. The first RUN cycle is a bubble
//     and the last pattern is held one extra cycle, so RUN lasts NPAT+1
//     cycles. The signature is identical to the default build.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start_i      start a run (acted on in IDLE or DONE only)
//   abort_i      synchronous return to IDLE, wins over start_i
//   resp_i       DUT response, [1]=s, [0]=cout
//   stim_o       registered DUT stimulus, [2]=x, [1]=y, [0]=cin
//   test_mode_o  selects BIST stimulus at the DUT input mux (RUN)
//   busy_o       high in RUN
//   done_o       high in DONE
//   pass_o       done_o && sig_o == GOLDEN
//   sig_o        signature register
// ----------------------------------------------------------------------------
module add_full_bist #(
    parameter int              NIN    = 3,
    parameter int              NOUT   = 2,
    parameter int              NPAT   = 8,
    parameter int              SIGW   = 8,
    parameter logic [SIGW-1:0] GOLDEN = 8'hC5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [NOUT-1:0] resp_i,
    output logic [NIN-1:0]  stim_o,
    output logic            test_mode_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [SIGW-1:0] sig_o
);

    // Wide enough to hold NPAT, which the registered-response build reaches.
    localparam int CW = $clog2(NPAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NIN-1:0]  stim_q, stim_d;
    logic [SIGW-1:0] sig_q, sig_d;
    logic [CW-1:0]   cnt_inc;
    logic [SIGW-1:0] sig_rot;

    assign cnt_inc = cnt_q + 1'b1;
    // MSB wraps into the LSB before the response is folded in.
    assign sig_rot = {sig_q[SIGW-2:0], sig_q[SIGW-1]};

`ifdef BIST_RESP_REG_EN
    logic [NOUT-1:0] resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resp_q <= '0;
        else        resp_q <= resp_i;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stim_q  <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    stim_d  = '0;
                    sig_d   = '0;
                end
            end
            RUN: begin
`ifdef BIST_RESP_REG_EN
                // resp_q lags stim by one cycle: skip slot 0, drain in slot NPAT.
                if (cnt_q != '0) sig_d = sig_rot ^ SIGW'(resp_q);
                if (cnt_q == CW'(NPAT)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    stim_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q != CW'(NPAT - 1)) stim_d = NIN'(cnt_inc);
                end
`else
                sig_d = sig_rot ^ SIGW'(resp_i);
                if (cnt_q == CW'(NPAT - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    stim_d  = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    stim_d = NIN'(cnt_inc);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            stim_d  = '0;
            sig_d   = '0;
        end
    end

    assign stim_o      = stim_q;
    assign sig_o       = sig_q;
    assign test_mode_o = (state_q == RUN);
    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign pass_o      = done_o && (sig_q == GOLDEN);

endmodule

// File: tb/tb_add_full_bist.sv
// ----------------------------------------------------------------------------
// tb_add_full_bist
//   Self-checking bench for add_full_bist with a behavioural full adder and
//   fault injection on s / cout. Expected signatures come from an arithmetic
//   model of the exhaustive pattern set.
// ----------------------------------------------------------------------------
module tb_add_full_bist;

    localparam int NPAT = 8;
`ifdef BIST_RESP_REG_EN
    localparam int RUN_LEN = NPAT + 1;
    localparam bit RREG    = 1'b1;
`else
    localparam int RUN_LEN = NPAT;
    localparam bit RREG    = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] resp;
    logic [2:0] stim;
    logic       tm, busy, done, pass;
    logic [7:0] sig;

    int fault = 0;   // 0 none, 1 s stuck-at-0, 2 cout stuck-at-1
    int n_chk = 0;
    int n_pass = 0;
    int fa_sum;

    always #5 clk = ~clk;

    add_full_bist dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .resp_i      (resp),
        .stim_o      (stim),
        .test_mode_o (tm),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .sig_o       (sig)
    );

    // Behavioural full adder with optional stuck-at faults.
    always_comb begin
        fa_sum  = int'(stim[2]) + int'(stim[1]) + int'(stim[0]);
        resp[1] = (fault == 1) ? 1'b0 : fa_sum[0];
        resp[0] = (fault == 2) ? 1'b1 : fa_sum[1];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Signature after compacting patterns 0..n-1 under fault f.
    function automatic int ref_sig(input int n, input int f);
        int s, c, sum, acc;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            sum = ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
            s = sum % 2;
            c = sum / 2;
            if (f == 1) s = 0;
            if (f == 2) c = 1;
            acc = (((acc << 1) | (acc >> 7)) & 255) ^ (s * 2 + c);
        end
        return acc;
    endfunction

    function automatic int exp_stim(input int i);
        if (RREG) return (i < NPAT) ? i : NPAT - 1;
        return i;
    endfunction

    function automatic int exp_ncomp(input int i);
        if (RREG) return (i == 0) ? 0 : i - 1;
        return i;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_tm"},   int'(tm),   0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_sig"},  int'(sig),  0);
        chk({tag, "_stim"}, int'(stim), 0);
    endtask

    task automatic check_cycle(input int i, input int f);
        chk("run_busy", int'(busy), 1);
        chk("run_tm",   int'(tm),   1);
        chk("run_stim", int'(stim), exp_stim(i));
        chk("run_sig",  int'(sig),  ref_sig(exp_ncomp(i), f));
    endtask

    // Entered on the negedge of RUN cycle 0; leaves on the first DONE negedge.
    task automatic run_body(input int f);
        int e;
        for (int i = 0; i < RUN_LEN; i++) begin
            check_cycle(i, f);
            @(negedge clk);
        end
        e = ref_sig(NPAT, f);
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        chk("end_tm",   int'(tm),   0);
        chk("end_stim", int'(stim), 0);
        chk("end_sig",  int'(sig),  e);
        chk("end_pass", int'(pass), int'(e == 'hC5));
    endtask

    initial begin
        int f, gap, a;
        // reset state
        #2 check_idle("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check_idle("idle");

        // fault-free run
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_body(0);
        chk("golden_sig", int'(sig), 'hC5);
        @(negedge clk);
        chk("done_hold", int'(done), 1);
        chk("sig_hold",  int'(sig),  'hC5);

        // s stuck-at-0
        fault = 1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_body(1);
        chk("sa0_sig",  int'(sig),  'h17);
        chk("sa0_pass", int'(pass), 0);
        fault = 0;

        // abort together with start at RUN cycle 4
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        @(negedge clk) check_idle("abort_stay");

        // async reset during pattern 3
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_stim", int'(stim), 3);
        #2 rst_n = 1'b0;
        #1 check_idle("areset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        run_body(0);

        // start held through a run: one DONE cycle, then a fresh run
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        run_body(0);
        @(negedge clk);
        start = 1'b0;
        run_body(0);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_idle("abort_done");

        // randomized runs: random fault, gap and optional abort point
        for (int it = 0; it < 8; it++) begin
            f   = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            fault = f;
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom_range(0, RUN_LEN - 1));
                for (int i = 0; i < a; i++) begin
                    check_cycle(i, f);
                    @(negedge clk);
                end
                abort = 1'b1;
                start = $urandom_range(0, 1) == 1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check_idle("rnd_abort");
            end else begin
                run_body(f);
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
            end
            fault = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
